// File: rtl/axi_config_rd_arb_if.sv
// Bundle of requester-side and register-side signals for the config read arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface axi_config_rd_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PORTS      = 2
);
  logic [PORTS-1:0]            s_rd;
  logic [PORTS*ADDR_WIDTH-1:0] s_raddr;
  logic [PORTS-1:0]            s_lock;
  logic [DATA_WIDTH-1:0]       s_rdata;
  logic [PORTS-1:0]            s_rvalid;
  logic                        s_rerr;
  logic                        m_rd;
  logic [ADDR_WIDTH-1:0]       m_raddr;
  logic [DATA_WIDTH-1:0]       m_rdata;
  logic                        m_rvalid;
  logic [PORTS-1:0]            grant;

  modport slave (
    input  s_rd, s_raddr, s_lock, m_rdata, m_rvalid,
    output s_rdata, s_rvalid, s_rerr, m_rd, m_raddr, grant
  );

  modport master (
    output s_rd, s_raddr, s_lock, m_rdata, m_rvalid,
    input  s_rdata, s_rvalid, s_rerr, m_rd, m_raddr, grant
  );
endinterface

// File: rtl/axi_config_rd_arb.sv
// Round-robin arbiter funnelling PORTS requesters onto one register read port,
// with a single outstanding read, optional locked bursts and a response timeout.
module axi_config_rd_arb #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          PORTS      = 2,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input logic                   clk,
  input logic                   rst,
  axi_config_rd_arb_if.slave    bus
);

  localparam int                    OW       = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [OW-1:0]         LAST_RST = OW'(PORTS - 1);
  localparam logic [15:0]           TO_LOAD  = 16'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] ERR_D    = DATA_WIDTH'(ERR_DATA);
  localparam logic [PORTS-1:0]      ONE      = PORTS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_q, last_d;
  logic [PORTS-1:0]      grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] m_raddr_q, m_raddr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
  logic                  s_rerr_q, s_rerr_d;
  logic                  m_rd_q, m_rd_d;
  logic [PORTS-1:0]      s_rvalid_q, s_rvalid_d;

  logic [ADDR_WIDTH-1:0] raddr_arr [PORTS];
  logic                  pick_found;
  logic [OW-1:0]         pick_idx;
  logic [OW-1:0]         cand_idx;

  // Unpack the flat requester address bus into one entry per port.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      raddr_arr[i] = bus.s_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Round-robin search starting at the port after the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand_idx   = OW'((int'(last_q) + k) % PORTS);
      pick_idx   = (bus.s_rd[cand_idx] && !pick_found) ? cand_idx : pick_idx;
      pick_found = pick_found | bus.s_rd[cand_idx];
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant_d    = grant_q;
    m_raddr_d  = m_raddr_q;
    cnt_d      = cnt_q;
    s_rdata_d  = s_rdata_q;
    s_rerr_d   = s_rerr_q;
    m_rd_d     = 1'b0;
    s_rvalid_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d   = pick_idx;
          grant_d   = ONE << pick_idx;
          m_raddr_d = raddr_arr[pick_idx];
          m_rd_d    = 1'b1;
          state_d   = ISSUE;
        end else begin
          grant_d   = '0;
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = TO_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // The cycle with cnt_q == 0 still accepts data; only then is it a timeout.
        if (bus.m_rvalid) begin
          s_rdata_d  = bus.m_rdata;
          s_rerr_d   = 1'b0;
          s_rvalid_d = grant_q;
          state_d    = RESP;
        end else if (cnt_q == 16'd0) begin
          s_rdata_d  = ERR_D;
          s_rerr_d   = 1'b1;
          s_rvalid_d = grant_q;
          state_d    = RESP;
        end else begin
          cnt_d      = cnt_q - 16'd1;
        end
      end
      RESP: begin
        if (bus.s_lock[owner_q] && bus.s_rd[owner_q]) begin
          m_raddr_d = raddr_arr[owner_q];
          m_rd_d    = 1'b1;
          state_d   = ISSUE;
        end else begin
          grant_d   = '0;
          last_d    = owner_q;
          state_d   = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      grant_q    <= '0;
      m_raddr_q  <= '0;
      cnt_q      <= 16'd0;
      s_rdata_q  <= '0;
      s_rerr_q   <= 1'b0;
      m_rd_q     <= 1'b0;
      s_rvalid_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      m_raddr_q  <= m_raddr_d;
      cnt_q      <= cnt_d;
      s_rdata_q  <= s_rdata_d;
      s_rerr_q   <= s_rerr_d;
      m_rd_q     <= m_rd_d;
      s_rvalid_q <= s_rvalid_d;
    end
  end

  assign bus.s_rdata  = s_rdata_q;
  assign bus.s_rvalid = s_rvalid_q;
  assign bus.s_rerr   = s_rerr_q;
  assign bus.m_rd     = m_rd_q;
  assign bus.m_raddr  = m_raddr_q;
  assign bus.grant    = grant_q;

endmodule

// File: doc/axi_config_rd_arb.md
AXI_CONFIG_RD_ARB -- requirements
Module: axi_config_rd_arb

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_WIDTH, 32, register address width.
- DATA_WIDTH, 32, register data width.
- PORTS, 2, requester count (2..8).
- TIMEOUT, 255, maximum cycles to wait for m_rvalid (1..65535).
- ERR_DATA, 32'hDEADBEEF, data returned on timeout (truncated or zero-extended to DATA_WIDTH).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, all logic on rising edge.
- rst, in, 1, reset; synchronous, active-high.
- s_rd, in, PORTS, per-requester read request level.
- s_raddr, in, PORTS*ADDR_WIDTH, per-requester address; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_lock, in, PORTS, requester asks to keep the grant after the current read.
- s_rdata, out, DATA_WIDTH, read data, shared by all requesters.
- s_rvalid, out, PORTS, one-cycle response strobe to the granted requester.
- s_rerr, out, 1, qualifies s_rvalid: response is a timeout.
- m_rd, out, 1, one-cycle read strobe to the register port.
- m_raddr, out, ADDR_WIDTH, register address, held stable from the m_rd cycle until the response.
- m_rdata, in, DATA_WIDTH, register read data.
- m_rvalid, in, 1, register data valid.
- grant, out, PORTS, one-hot current owner (debug/observability).

Function
REQ-003 One read outstanding on the m_ side at a time.
REQ-004 States are IDLE, ISSUE, WAIT and RESP, encoded in 2 bits.
REQ-005 IDLE: if any s_rd bit is high, select the owner round-robin, starting from the index after the last owner, with lowest index first after reset. Capture its s_raddr into m_raddr, set grant, and go to ISSUE. Otherwise stay in IDLE with grant=0.
REQ-006 ISSUE: m_rd=1 for exactly this cycle, load the timeout counter with TIMEOUT, go to WAIT.
REQ-007 WAIT, m_rvalid=1: register m_rdata into s_rdata, s_rerr=0, go to RESP.
REQ-008 WAIT, m_rvalid=0: decrement the counter. When the counter reaches 0 without m_rvalid, s_rdata=ERR_DATA, s_rerr=1, go to RESP.
REQ-009 RESP: s_rvalid[owner]=1 for exactly one cycle, and s_rdata/s_rerr are valid in the same cycle.
REQ-010 RESP exit with s_lock[owner]=1 and s_rd[owner]=1 in the RESP cycle: keep the grant, capture the new s_raddr[owner], go to ISSUE. This is a back-to-back burst with no rearbitration.
REQ-011 Any other RESP exit: clear grant, record the owner as last, go to IDLE.
REQ-012 Latency with fixed timing: s_rd high in IDLE gives m_rd 1 cycle later. m_rvalid in cycle N gives s_rvalid in cycle N+1. Idle-to-idle minimum is 4 cycles per read.
REQ-013 m_rvalid received outside WAIT is ignored. A late response after a timeout is ignored and is never delivered to the next owner.
REQ-014 A requester drops s_rd at will. A drop after grant does not abort the transaction; the response is still strobed.
REQ-015 Requester contract: hold s_rd and s_raddr until s_rvalid. A new address is sampled only in IDLE or in the locked RESP cycle.
REQ-016 s_rdata holds its value between responses. Non-owner s_rvalid bits are always 0.
REQ-017 grant is one-hot or zero, never multi-hot.

Reset
REQ-018 rst high at a clock edge gives, at the next cycle:
- state=IDLE, grant=0, m_rd=0, s_rvalid=0, s_rerr=0.
- m_raddr=0, s_rdata=0, counter=0, last owner = PORTS-1.
REQ-019 Reset mid-transaction abandons it with no s_rvalid. A m_rvalid arriving after reset is ignored per REQ-013.

Verification
REQ-020 Single read: s_rd[0]=1, s_raddr0=0x10, m_rvalid 2 cycles after m_rd with 0x1234 -> m_rd once at 0x10, s_rvalid[0] one cycle, s_rdata=0x1234, s_rerr=0.
REQ-021 Contention: s_rd=2'b11 held for 4 reads, no lock -> grant order 0,1,0,1 and each s_rvalid goes to the matching port.
REQ-022 Lock burst: port 1 with s_lock=1 for 3 reads at 0x0,0x4,0x8 while port 0 also requests -> three consecutive port-1 reads with ISSUE immediately after RESP, then port 0 is served.
REQ-023 Timeout: TIMEOUT=4, m_rvalid never asserted -> s_rvalid 4+1 cycles after WAIT entry, s_rdata=ERR_DATA, s_rerr=1. A late m_rvalid is then ignored.
REQ-024 Reset in WAIT: rst pulsed while waiting -> no s_rvalid, all outputs at reset values. The next request is arbitrated from port 0.
REQ-025 Throughout all scenarios, check grant is one-hot or zero and at most one m_rd occurs per s_rvalid.
